// File: rtl/heap_sort_node_delay_if.sv
// Bus bundle for one heapsort sift-down node: upstream token, child-store
// left/right ports, parent-store bottom port and downstream token.
interface heap_sort_node_delay_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic                  in_ready;

  logic [ADDR_WIDTH-1:0] lm_addr;
  logic [DATA_WIDTH-1:0] lm_din;
  logic                  lm_we;
  logic [DATA_WIDTH-1:0] lm_dout;

  logic [ADDR_WIDTH-1:0] rm_addr;
  logic [DATA_WIDTH-1:0] rm_din;
  logic                  rm_we;
  logic [DATA_WIDTH-1:0] rm_dout;

  logic [ADDR_WIDTH-1:0] up_addr;
  logic [DATA_WIDTH-1:0] up_din;
  logic                  up_we;
  logic                  up_branch;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH:0]   out_addr;
  logic                  out_ready;

  // Node side
  modport slave (
    input  in_valid, in_data, in_addr, lm_dout, rm_dout, out_ready,
    output in_ready, lm_addr, lm_din, lm_we, rm_addr, rm_din, rm_we,
           up_addr, up_din, up_we, up_branch, out_valid, out_data, out_addr
  );

  // Environment side (upstream node, stores, downstream node)
  modport master (
    output in_valid, in_data, in_addr, lm_dout, rm_dout, out_ready,
    input  in_ready, lm_addr, lm_din, lm_we, rm_addr, rm_din, rm_we,
           up_addr, up_din, up_we, up_branch, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/heap_sort_node_delay.sv
// Heapsort sift-down compare/swap node for one-cycle-latency stores.
// Reads a child pair, writes the winner into the parent slot and, on a swap,
// forwards the displaced value to the next node down.
// Optional: define HEAP_SORT_MIN_HEAP_EN for a min-heap (default max-heap).
module heap_sort_node_delay #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int LEVEL      = 1,
  parameter int LAST       = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  heap_sort_node_delay_if.slave  io
);

  // LEVEL only matters to whoever wires the parent store; sanity-check it here.
  if (LEVEL < 0 || ADDR_WIDTH < 1) begin : g_param_chk
    $error("heap_sort_node_delay: bad LEVEL/ADDR_WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RD, S_CMP, S_OUT} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  sel_q;

  logic [DATA_WIDTH-1:0] c_val;
  logic                  sel;
  logic                  keep;

  // Child select and keep/swap decision; only meaningful in CMP.
  always_comb begin
`ifdef HEAP_SORT_MIN_HEAP_EN
    sel  = io.rm_dout < io.lm_dout;
    c_val = sel ? io.rm_dout : io.lm_dout;
    keep = data_q <= c_val;
`else
    sel  = io.rm_dout > io.lm_dout;
    c_val = sel ? io.rm_dout : io.lm_dout;
    keep = data_q >= c_val;
`endif
  end

  // State and token registers; sel_q only moves on a swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      data_q <= '0;
      addr_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && io.in_valid) begin
        data_q <= io.in_data;
        addr_q <= io.in_addr;
      end
      if (state == S_CMP && !keep) sel_q <= sel;
    end
  end

  // Next-state: fixed RD/CMP walk, OUT only for a swapping non-last node.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (io.in_valid) state_nxt = S_RD;
      S_RD:   state_nxt = S_CMP;
      S_CMP:  if (keep || LAST != 0) state_nxt = S_IDLE;
              else                   state_nxt = S_OUT;
      S_OUT:  if (io.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strobes; suppressed while reset is held so an aborted token never writes.
  always_comb begin
    io.in_ready  = (state == S_IDLE);
    io.up_we     = 1'b0;
    io.up_din    = data_q;
    io.lm_we     = 1'b0;
    io.rm_we     = 1'b0;
    io.out_valid = 1'b0;
    if (!rst) begin
      case (state)
        S_CMP: begin
          io.up_we = 1'b1;
          if (!keep) begin
            io.up_din = c_val;
            io.lm_we  = ~sel;
            io.rm_we  = sel;
          end
        end
        S_OUT:   io.out_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Address/data fan-out is purely from the token registers.
  assign io.lm_addr   = addr_q;
  assign io.rm_addr   = addr_q;
  assign io.lm_din    = data_q;
  assign io.rm_din    = data_q;
  assign io.up_addr   = addr_q >> 1;
  assign io.up_branch = addr_q[0];
  assign io.out_data  = data_q;
  assign io.out_addr  = {addr_q, sel_q};

endmodule

// File: tb/tb_heap_sort_node_delay.sv
// Randomized bench for heap_sort_node_delay: instance 0 is an inner node,
// instance 1 is the last node. Each keeps its own one-cycle-latency stores.
module tb_heap_sort_node_delay;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  heap_sort_node_delay_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus [2] ();

  heap_sort_node_delay #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL(1), .LAST(0))
    u_dut0 (.clk(clk), .rst(rst), .io(bus[0]));
  heap_sort_node_delay #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEVEL(1), .LAST(1))
    u_dut1 (.clk(clk), .rst(rst), .io(bus[1]));

  logic [1:0]          in_valid;
  logic [DW-1:0]       in_data;
  logic [AW-1:0]       in_addr;
  logic                out_ready;
  logic [1:0]          pre_we;
  logic [AW-1:0]       pre_addr;
  logic [DW-1:0]       pre_l, pre_r;

  logic [1:0]          in_ready_o, up_we_o, up_branch_o, lm_we_o, rm_we_o, out_valid_o;
  logic [1:0][AW-1:0]  up_addr_o, lm_addr_o, rm_addr_o;
  logic [1:0][DW-1:0]  up_din_o, lm_din_o, rm_din_o, out_data_o;
  logic [1:0][AW:0]    out_addr_o;

  for (genvar g = 0; g < 2; g++) begin : g_node
    logic [DW-1:0] ml [32];
    logic [DW-1:0] mr [32];
    logic [DW-1:0] lq, rq;

    assign bus[g].in_valid  = in_valid[g];
    assign bus[g].in_data   = in_data;
    assign bus[g].in_addr   = in_addr;
    assign bus[g].out_ready = out_ready;
    assign bus[g].lm_dout   = lq;
    assign bus[g].rm_dout   = rq;

    assign in_ready_o[g]  = bus[g].in_ready;
    assign up_we_o[g]     = bus[g].up_we;
    assign up_branch_o[g] = bus[g].up_branch;
    assign up_addr_o[g]   = bus[g].up_addr;
    assign up_din_o[g]    = bus[g].up_din;
    assign lm_we_o[g]     = bus[g].lm_we;
    assign rm_we_o[g]     = bus[g].rm_we;
    assign lm_addr_o[g]   = bus[g].lm_addr;
    assign rm_addr_o[g]   = bus[g].rm_addr;
    assign lm_din_o[g]    = bus[g].lm_din;
    assign rm_din_o[g]    = bus[g].rm_din;
    assign out_valid_o[g] = bus[g].out_valid;
    assign out_data_o[g]  = bus[g].out_data;
    assign out_addr_o[g]  = bus[g].out_addr;

    // Child store pair: registered read, bench backdoor preload has priority.
    always @(posedge clk) begin
      lq <= ml[bus[g].lm_addr];
      rq <= mr[bus[g].rm_addr];
      if (pre_we[g]) begin
        ml[pre_addr] <= pre_l;
        mr[pre_addr] <= pre_r;
      end else begin
        if (bus[g].lm_we) ml[bus[g].lm_addr] <= bus[g].lm_din;
        if (bus[g].rm_we) mr[bus[g].rm_addr] <= bus[g].rm_din;
      end
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the sifted value sinks below the better child, or stays put.
  task automatic model(input logic [DW-1:0] d, input logic [DW-1:0] l, input logic [DW-1:0] r,
                       output logic sel_e, output logic [DW-1:0] c_e, output logic swap_e);
`ifdef HEAP_SORT_MIN_HEAP_EN
    if (r < l) begin sel_e = 1'b1; c_e = r; end
    else       begin sel_e = 1'b0; c_e = l; end
    swap_e = d > c_e;
`else
    if (r > l) begin sel_e = 1'b1; c_e = r; end
    else       begin sel_e = 1'b0; c_e = l; end
    swap_e = d < c_e;
`endif
  endtask

  task automatic token(input int k, input logic [DW-1:0] d, input logic [AW-1:0] a,
                       input logic [DW-1:0] l, input logic [DW-1:0] r,
                       input int stall, input bit rst_cmp);
    logic sel_e, swap_e;
    logic [DW-1:0] c_e;
    model(d, l, r, sel_e, c_e, swap_e);

    @(negedge clk);
    pre_we[k] = 1'b1; pre_addr = a; pre_l = l; pre_r = r;
    @(negedge clk);
    pre_we = '0;
    chk("in_ready_idle", 64'(in_ready_o[k]), 64'(1));
    in_data = d; in_addr = a; in_valid[k] = 1'b1;
    @(negedge clk);  // RD
    in_valid = '0;
    chk("rd_quiet", 64'({in_ready_o[k], up_we_o[k], lm_we_o[k], rm_we_o[k]}), 64'(0));
    @(negedge clk);  // CMP
    if (rst_cmp) begin
      rst = 1'b1;
      #1;
      chk("rst_cmp_we", 64'({up_we_o[k], lm_we_o[k], rm_we_o[k]}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      chk("rst_idle", 64'({in_ready_o[k], out_valid_o[k]}), 64'(2'b10));
      return;
    end
    chk("cmp_up_we", 64'(up_we_o[k]), 64'(1));
    chk("cmp_up_din", 64'(up_din_o[k]), 64'(swap_e ? c_e : d));
    chk("cmp_up_addr", 64'(up_addr_o[k]), 64'(a >> 1));
    chk("cmp_up_branch", 64'(up_branch_o[k]), 64'(a[0]));
    chk("cmp_lm_we", 64'(lm_we_o[k]), 64'(swap_e && !sel_e));
    chk("cmp_rm_we", 64'(rm_we_o[k]), 64'(swap_e && sel_e));
    chk("cmp_child_addr", 64'({lm_addr_o[k], rm_addr_o[k]}), 64'({a, a}));
    if (swap_e) chk("cmp_child_din", 64'(sel_e ? rm_din_o[k] : lm_din_o[k]), 64'(d));
    chk("cmp_out_valid", 64'(out_valid_o[k]), 64'(0));

    if (swap_e && k == 0) begin
      out_ready = (stall == 0);
      @(negedge clk);  // OUT
      for (int i = 0; i < stall; i++) begin
        chk("out_hold", 64'({out_valid_o[k], out_data_o[k], out_addr_o[k], in_ready_o[k],
                             up_we_o[k], lm_we_o[k], rm_we_o[k]}),
            64'({1'b1, d, a, sel_e, 4'b0000}));
        in_valid[k] = (i == 0);
        in_data = ~d; in_addr = ~a;
        @(negedge clk);
        in_valid = '0;
      end
      out_ready = 1'b1;
      chk("out_tok", 64'({out_valid_o[k], out_data_o[k], out_addr_o[k]}), 64'({1'b1, d, a, sel_e}));
      @(negedge clk);
      chk("out_done", 64'({out_valid_o[k], in_ready_o[k]}), 64'(2'b01));
    end else begin
      @(negedge clk);
      chk("idle_back", 64'({out_valid_o[k], in_ready_o[k]}), 64'(2'b01));
    end
  endtask

  initial begin
    logic [DW-1:0] rd, rl, rr;
    logic [AW-1:0] ra;
    rst = 1'b1; in_valid = '0; in_data = '0; in_addr = '0; out_ready = 1'b1;
    pre_we = 2'b11; pre_addr = '0; pre_l = 32'h11; pre_r = 32'h22;
    @(negedge clk);
    pre_we = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", 64'(in_ready_o[k]), 64'(1));
      chk("rst_strobes", 64'({up_we_o[k], lm_we_o[k], rm_we_o[k], out_valid_o[k]}), 64'(0));
      chk("rst_addrs", 64'({lm_addr_o[k], rm_addr_o[k], up_addr_o[k]}), 64'(0));
    end

    token(0, 32'h50, 5'd3, 32'h20, 32'h30, 0, 1'b0);
    token(0, 32'h10, 5'd2, 32'h40, 32'h70, 0, 1'b0);
    token(0, 32'h10, 5'd2, 32'h40, 32'h70, 4, 1'b0);
    token(1, 32'h08, 5'd5, 32'h40, 32'h40, 0, 1'b0);
`ifdef HEAP_SORT_MIN_HEAP_EN
    token(0, 32'h50, 5'd6, 32'h20, 32'h30, 0, 1'b1);
`else
    token(0, 32'h08, 5'd6, 32'h20, 32'h30, 0, 1'b1);
`endif
    token(0, 32'h50, 5'd3, 32'h20, 32'h30, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rd = DW'($urandom_range(0, 15));
      rl = DW'($urandom_range(0, 15));
      rr = (n % 5 == 0) ? rl : DW'($urandom_range(0, 15));
      ra = AW'($urandom_range(0, 31));
      if (n % 7 == 3) rd = $urandom;
      token(int'($urandom_range(0, 1)), rd, ra, rl, rr, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
